// File: rtl/regfile_pkg.sv
// Shared constants and bus-width helpers for the register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_D = 32;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Active-low enable levels
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_DATA_W-1:0] data_t;

  // Most significant bit index of a bus of the given width
  function automatic int unsigned msb(input int unsigned width);
    return width - 1;
  endfunction

  // Index width needed to address a given number of words (at least 1)
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile.sv
// Single-port register file: synchronous active-low write, combinational read,
// synchronous active-high clear. Out-of-range addresses write nothing, read 0.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_D = DEF_DATA_D
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic [msb(ADDR_W):0]   addr,
  input  logic [msb(DATA_W):0]   d_in,
  input  logic                   we_,
  output logic [msb(DATA_W):0]   d_out
);

  localparam int unsigned       IDX_W = idx_width(DATA_D);
  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W + 1)'(DATA_D);

  logic [DATA_W-1:0] word [DATA_D];
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign in_range = ({1'b0, addr} < DEPTH);
  assign idx      = addr[IDX_W-1:0];

  // Storage update: clear has priority over write
  always_ff @(posedge clk) begin
    if (reset_ == HIGH) begin
      word <= '{default: '0};
    end else if (we_ == ENABLE_ && in_range) begin
      word[idx] <= d_in;
    end
  end

  // Combinational read mux; out-of-range reads return zero
  always_comb begin
    d_out = '0;
    if (in_range) begin
      d_out = word[idx];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Randomized scoreboard bench for regfile: a full-depth instance and a
// DATA_D=20 instance share the same stimulus and are checked against arrays.
module tb_regfile;

  logic        clk = 1'b0;
  logic        reset_;
  logic [4:0]  addr;
  logic [31:0] d_in;
  logic        we_;
  logic [31:0] d_out32;
  logic [31:0] d_out20;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] e32;
    logic [31:0] e20;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m32 [32];
  logic [31:0] m20 [20];

  always #5 clk = ~clk;

  regfile #(.DATA_W(32), .ADDR_W(5), .DATA_D(32)) dut32 (
    .clk(clk), .reset_(reset_), .addr(addr), .d_in(d_in), .we_(we_), .d_out(d_out32)
  );

  regfile #(.DATA_W(32), .ADDR_W(5), .DATA_D(20)) dut20 (
    .clk(clk), .reset_(reset_), .addr(addr), .d_in(d_in), .we_(we_), .d_out(d_out20)
  );

  function automatic logic [31:0] rd32(input logic [4:0] a);
    return m32[a];
  endfunction

  function automatic logic [31:0] rd20(input logic [4:0] a);
    if (int'(a) < 20) return m20[a];
    return 32'h0;
  endfunction

  // Monitor: compare every queued expectation at the falling edge
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        if (d_out32 !== e.e32) begin
          n_fail++;
          $display("FAIL %s d32 addr=%0d got=%h want=%h", e.tag, e.a, d_out32, e.e32);
        end
        n_checks++;
        if (d_out20 !== e.e20) begin
          n_fail++;
          $display("FAIL %s d20 addr=%0d got=%h want=%h", e.tag, e.a, d_out20, e.e20);
        end
      end
    end
  end

  // Drive one cycle, expect the pre-edge read, then apply the edge to the model
  task automatic step(input logic r, input logic w, input logic [4:0] a,
                      input logic [31:0] d, input string tag);
    exp_t e;
    reset_ = r; we_ = w; addr = a; d_in = d;
    e.a = a; e.e32 = rd32(a); e.e20 = rd20(a); e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    if (r) begin
      foreach (m32[i]) m32[i] = '0;
      foreach (m20[i]) m20[i] = '0;
    end else if (!w) begin
      m32[a] = d;
      if (int'(a) < 20) m20[a] = d;
    end
    #1;
  endtask

  initial begin
    foreach (m32[i]) m32[i] = $urandom;
    foreach (m20[i]) m20[i] = $urandom;
    reset_ = 1'b1; we_ = 1'b1; addr = '0; d_in = '0;
    @(posedge clk); #1;
    // Settle model to reset state without checking the unknown power-up content
    foreach (m32[i]) m32[i] = '0;
    foreach (m20[i]) m20[i] = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 5'(i), $urandom, "reset_read");

    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 5'(i), 32'(i), "sweep_pre");
      step(1'b0, 1'b1, 5'(i), $urandom, "sweep_post");
      step(1'b0, 1'b1, 5'd0, $urandom, "sweep_idle");
    end

    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, "we_off");
    step(1'b0, 1'b1, 5'd5, 32'h0, "we_off_after");

    step(1'b0, 1'b0, 5'd7, 32'h1234, "rbw_before");
    step(1'b0, 1'b1, 5'd7, 32'h0, "rbw_after");

    step(1'b1, 1'b0, 5'd3, 32'hFFFF, "rst_prio");
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 5'(i), $urandom, "rst_prio_read");

    step(1'b0, 1'b0, 5'd25, 32'hAA, "oor_write");
    step(1'b0, 1'b1, 5'd25, 32'h0, "oor_read");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 5'(i), 32'h0, "oor_others");

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 31)), $urandom, "random");
    end

    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
